// File: rtl/multi_debouncer.sv
// ============================================================================
// Module   : multi_debouncer
// Purpose  : N-channel push-button conditioner. Each channel has a two-flop
//            synchroniser, press and release debouncing, press/release
//            strobes and a long-press flag.
// Option   : define MULTI_DEBOUNCER_AUTOREPEAT_EN to repeat press_pulse
//            while long_press is held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debouncer #(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = 10000,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] button_in,
   output logic [N_CH-1:0] button_level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_press
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);
`endif

   if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("multi_debouncer: cycle parameters must be >= 1");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic          s1, s2;
      logic          level, press, rel, lng;
      logic [CW-1:0] cnt;
      logic [HW-1:0] hcnt;
      logic          accept;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
      logic [RW-1:0] rcnt;
`endif

      // A level change is accepted on the last of STABLE_CYCLES mismatch cycles
      assign accept = (s2 != level) && (cnt == STABLE_LAST);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            lng   <= 1'b0;
            cnt   <= '0;
            hcnt  <= '0;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
            rcnt  <= '0;
`endif
         end else begin
            s1    <= button_in[i];
            s2    <= s1;
            press <= accept && !level;
            rel   <= accept && level;

            if (s2 == level) begin
               cnt <= '0;
            end else if (accept) begin
               cnt   <= '0;
               level <= ~level;
            end else begin
               cnt <= cnt + CW'(1);
            end

            // Long-press flag drops on the same edge that the level falls
            if (!level || accept) begin
               hcnt <= '0;
               lng  <= 1'b0;
            end else if (hcnt != HOLD_MAX) begin
               hcnt <= hcnt + HW'(1);
               if (hcnt == HOLD_LAST) begin
                  lng <= 1'b1;
               end
            end

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
            if (!level || accept) begin
               rcnt <= '0;
            end else if (hcnt == HOLD_LAST) begin
               press <= 1'b1;
               rcnt  <= '0;
            end else if (lng) begin
               if (rcnt == REPEAT_LAST) begin
                  press <= 1'b1;
                  rcnt  <= '0;
               end else begin
                  rcnt <= rcnt + RW'(1);
               end
            end
`endif
         end
      end

      assign button_level[i]  = level;
      assign press_pulse[i]   = press;
      assign release_pulse[i] = rel;
      assign long_press[i]    = lng;
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_debouncer.sv
// ============================================================================
// Module   : tb_multi_debouncer
// Purpose  : Directed self-checking bench for multi_debouncer (N_CH=2,
//            STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_debouncer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] button_in;
   logic [1:0] button_level;
   logic [1:0] press_pulse;
   logic [1:0] release_pulse;
   logic [1:0] long_press;

   int n_cmp = 0;
   int n_err = 0;

   multi_debouncer #(
      .N_CH          (2),
      .STABLE_CYCLES (4),
      .HOLD_CYCLES   (10),
      .REPEAT_CYCLES (3)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .button_in     (button_in),
      .button_level  (button_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " level"},   32'(button_level),  32'h0);
      check({tag, " press"},   32'(press_pulse),   32'h0);
      check({tag, " release"}, 32'(release_pulse), 32'h0);
      check({tag, " long"},    32'(long_press),    32'h0);
   endtask

   initial begin
      int         press_cnt;
      int         rel_cnt;
      int         level_cnt;
      int         exp_repeats;
      logic [7:0] bounce;

      reset_n   = 1'b0;
      button_in = 2'b00;
      #1;
      check_all_zero("reset");
      #11 reset_n = 1'b1;
      repeat (3) tick();
      check_all_zero("idle");

      // Clean press on ch0; next edge is edge 0
      button_in = 2'b01;
      repeat (5) tick();
      check("press edge4 level", 32'(button_level), 32'h0);
      tick();
      check("press edge5 level", 32'(button_level), 32'h1);
      check("press edge5 pulse", 32'(press_pulse),  32'h1);
      tick();
      check("press edge6 pulse", 32'(press_pulse),  32'h0);
      check("press edge6 level", 32'(button_level), 32'h1);

      // Long press: rises 10 cycles after the press strobe (edge 15)
      repeat (8) tick();
      check("long edge14", 32'(long_press), 32'h0);
      press_cnt = 0;
      tick();
      check("long edge15", 32'(long_press), 32'h1);
      press_cnt += 32'(press_pulse[0]);
      repeat (10) begin
         tick();
         press_cnt += 32'(press_pulse[0]);
      end
      check("long edge25", 32'(long_press), 32'h1);
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
      exp_repeats = 4;
`else
      exp_repeats = 0;
`endif
      check("repeat press count", 32'(press_cnt), 32'(exp_repeats));

      // Release before edge 26: level falls at edge 31
      button_in = 2'b00;
      repeat (5) tick();
      check("release edge30 level", 32'(button_level),  32'h1);
      check("release edge30 pulse", 32'(release_pulse), 32'h0);
      check("release edge30 long",  32'(long_press),    32'h1);
      tick();
      check("release edge31 level", 32'(button_level),  32'h0);
      check("release edge31 pulse", 32'(release_pulse), 32'h1);
      check("release edge31 long",  32'(long_press),    32'h0);
      check("release edge31 press", 32'(press_pulse),   32'h0);
      tick();
      check("release edge32 pulse", 32'(release_pulse), 32'h0);

      // Bounce: three mismatches in a row never reach the acceptance count
      bounce    = 8'b0111_0111;
      level_cnt = 0;
      press_cnt = 0;
      for (int j = 0; j < 8; j++) begin
         button_in[0] = bounce[j];
         tick();
         level_cnt += 32'(button_level[0]);
         press_cnt += 32'(press_pulse[0]);
      end
      button_in = 2'b00;
      repeat (6) begin
         tick();
         level_cnt += 32'(button_level[0]);
         press_cnt += 32'(press_pulse[0]);
      end
      check("bounce level cycles", 32'(level_cnt), 32'h0);
      check("bounce press count",  32'(press_cnt), 32'h0);

      // Async reset while held and long-pressed
      button_in = 2'b01;
      repeat (6) tick();
      repeat (10) tick();
      check("pre-reset level", 32'(button_level), 32'h1);
      check("pre-reset long",  32'(long_press),   32'h1);
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("async reset");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      press_cnt = 0;
      rel_cnt   = 0;
      repeat (5) begin
         tick();
         press_cnt += 32'(press_pulse[0]);
         rel_cnt   += 32'(release_pulse[0]);
      end
      check("post-reset early press", 32'(press_cnt), 32'h0);
      tick();
      check("post-reset press", 32'(press_pulse),  32'h1);
      check("post-reset level", 32'(button_level), 32'h1);
      repeat (3) begin
         tick();
         rel_cnt += 32'(release_pulse[0]);
      end
      check("post-reset no release", 32'(rel_cnt), 32'h0);

      // Independent channels
      button_in = 2'b00;
      repeat (8) tick();
      check("indep idle level", 32'(button_level), 32'h0);
      button_in = 2'b11;
      repeat (5) tick();
      check("indep early press", 32'(press_pulse), 32'h0);
      tick();
      check("indep both press", 32'(press_pulse),  32'h3);
      check("indep both level", 32'(button_level), 32'h3);
      tick();
      button_in = 2'b01;
      rel_cnt   = 0;
      repeat (5) begin
         tick();
         rel_cnt += 32'(release_pulse != 2'b00);
      end
      check("indep early release", 32'(rel_cnt), 32'h0);
      tick();
      check("indep release ch1", 32'(release_pulse), 32'h2);
      check("indep level ch0",   32'(button_level),  32'h1);
      check("indep press none",  32'(press_pulse),   32'h0);
      tick();
      check("indep release done", 32'(release_pulse), 32'h0);
      check("indep level hold",   32'(button_level),  32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
